accel_accumulator: RTL and testbench

- Acceleration stage directly upstream of the per-axis leapfrog integrator.
- Consumes a stream of pairwise gravity terms for one target body on one axis. Each term is the triple (G*m_j, dx_j, 1/r_j^3).
- Forms term_j = gm_j * inv_r3_j * dx_j in a 3-stage multiply/accumulate pipeline and sums over the frame.
- Presents the saturated sum as accel with a valid/ready handshake. accel_valid & accel_ready is used directly as the integrator's enable strobe.

---
 rtl/accel_accumulator_if.sv | 36 +++
 rtl/accel_accumulator.sv | 189 ++++++++++++++++++
 tb/tb_accel_accumulator.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_accumulator_if.sv
// Stream/result bundle for accel_accumulator: term beats in, saturated frame sum out.
// sat_flag exists only when ACCEL_SAT_FLAG_EN is defined.
interface accel_accumulator_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_gm;
  logic signed [WIDTH-1:0] in_inv_r3;
  logic signed [WIDTH-1:0] in_dx;
  logic                    in_last;
  logic signed [WIDTH-1:0] accel;
  logic                    accel_valid;
  logic                    accel_ready;
  logic [CNT_W-1:0]        term_count;
`ifdef ACCEL_SAT_FLAG_EN
  logic                    sat_flag;
`endif

  modport slave (
    input  in_valid, in_gm, in_inv_r3, in_dx, in_last, accel_ready,
    output in_ready, accel, accel_valid, term_count
`ifdef ACCEL_SAT_FLAG_EN
    , sat_flag
`endif
  );

  modport master (
    output in_valid, in_gm, in_inv_r3, in_dx, in_last, accel_ready,
    input  in_ready, accel, accel_valid, term_count
`ifdef ACCEL_SAT_FLAG_EN
    , sat_flag
`endif
  );
endinterface

// File: rtl/accel_accumulator.sv
// Per-axis gravity term accumulator: sums sat(gm*inv_r3*dx) over a frame in a 3-stage pipeline.
// Define ACCEL_SAT_FLAG_EN to add the sticky bus.sat_flag output.
module accel_accumulator #(
  parameter int WIDTH      = 64,
  parameter int FRACTIONAL = 32,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                reset_n,
  accel_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  typedef logic signed [WIDTH-1:0]   word_t;
  typedef logic signed [2*WIDTH-1:0] wide_t;

  localparam word_t WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic wide_t mul_shift(input word_t a, input word_t b);
    wide_t ea;
    wide_t eb;
    ea = a;
    eb = b;
    return (ea * eb) >>> FRACTIONAL;
  endfunction

  // A shifted product fits in WIDTH bits only if its top WIDTH+1 bits are a pure sign extension.
  function automatic logic clamps(input wide_t v);
    logic [WIDTH:0] hi;
    hi = v[2*WIDTH-1:WIDTH-1];
    return !((hi == '0) || (hi == '1));
  endfunction

  function automatic word_t sat_word(input wide_t v);
    if (!clamps(v)) return v[WIDTH-1:0];
    return v[2*WIDTH-1] ? WORD_MIN : WORD_MAX;
  endfunction

  state_t           state_q, state_d;
  logic             v0_q, v0_d, first0_q, first0_d, last0_q, last0_d;
  word_t            gm0_q, gm0_d, ir0_q, ir0_d, dx0_q, dx0_d;
  logic             v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  word_t            p1_q, p1_d, dx1_q, dx1_d;
  logic             v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
  word_t            p2_q, p2_d;
  word_t            acc_q, acc_d;
  logic             done3_q, done3_d;
  word_t            accel_q, accel_d;
  logic             accel_valid_q, accel_valid_d;
  logic [CNT_W-1:0] term_count_q, term_count_d;

  logic               in_ready;
  logic               accept;
  wide_t              prod1;
  wide_t              prod2;
  logic [WIDTH:0]     sum3;
  logic               acc_clamp;

  assign in_ready  = reset_n && (state_q == IDLE || state_q == ACCUM);
  assign accept    = bus.in_valid && in_ready;
  assign prod1     = mul_shift(gm0_q, ir0_q);
  assign prod2     = mul_shift(p1_q, dx1_q);
  assign sum3      = {acc_q[WIDTH-1], acc_q} + {p2_q[WIDTH-1], p2_q};
  assign acc_clamp = sum3[WIDTH] != sum3[WIDTH-1];

  always_comb begin
    state_d       = state_q;
    accel_d       = accel_q;
    accel_valid_d = accel_valid_q;
    term_count_d  = term_count_q;

    v0_d     = accept;
    first0_d = accept && (state_q == IDLE);
    last0_d  = accept && bus.in_last;
    gm0_d    = bus.in_gm;
    ir0_d    = bus.in_inv_r3;
    dx0_d    = bus.in_dx;

    v1_d     = v0_q;
    first1_d = first0_q;
    last1_d  = last0_q;
    p1_d     = sat_word(prod1);
    dx1_d    = dx0_q;

    v2_d     = v1_q;
    first2_d = first1_q;
    last2_d  = last1_q;
    p2_d     = sat_word(prod2);

    acc_d = acc_q;
    if (v2_q) begin
      if (first2_q)       acc_d = p2_q;
      else if (acc_clamp) acc_d = sum3[WIDTH] ? WORD_MIN : WORD_MAX;
      else                acc_d = sum3[WIDTH-1:0];
    end
    done3_d = v2_q && last2_q;

    if (accept) begin
      if (state_q == IDLE)          term_count_d = CNT_W'(1);
      else if (term_count_q != '1)  term_count_d = term_count_q + 1'b1;
    end

    case (state_q)
      IDLE:  if (accept) state_d = bus.in_last ? DRAIN : ACCUM;
      ACCUM: if (accept && bus.in_last) state_d = DRAIN;
      DRAIN: if (done3_q) begin
        accel_d       = acc_q;
        accel_valid_d = 1'b1;
        state_d       = DONE;
      end
      DONE:  if (bus.accel_ready) begin
        accel_valid_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      v0_q          <= 1'b0;
      first0_q      <= 1'b0;
      last0_q       <= 1'b0;
      gm0_q         <= '0;
      ir0_q         <= '0;
      dx0_q         <= '0;
      v1_q          <= 1'b0;
      first1_q      <= 1'b0;
      last1_q       <= 1'b0;
      p1_q          <= '0;
      dx1_q         <= '0;
      v2_q          <= 1'b0;
      first2_q      <= 1'b0;
      last2_q       <= 1'b0;
      p2_q          <= '0;
      acc_q         <= '0;
      done3_q       <= 1'b0;
      accel_q       <= '0;
      accel_valid_q <= 1'b0;
      term_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      v0_q          <= v0_d;
      first0_q      <= first0_d;
      last0_q       <= last0_d;
      gm0_q         <= gm0_d;
      ir0_q         <= ir0_d;
      dx0_q         <= dx0_d;
      v1_q          <= v1_d;
      first1_q      <= first1_d;
      last1_q       <= last1_d;
      p1_q          <= p1_d;
      dx1_q         <= dx1_d;
      v2_q          <= v2_d;
      first2_q      <= first2_d;
      last2_q       <= last2_d;
      p2_q          <= p2_d;
      acc_q         <= acc_d;
      done3_q       <= done3_d;
      accel_q       <= accel_d;
      accel_valid_q <= accel_valid_d;
      term_count_q  <= term_count_d;
    end
  end

`ifdef ACCEL_SAT_FLAG_EN
  logic sat_q, sat_d;

  // The pipeline is always empty when a frame's first beat arrives, so clearing here loses nothing.
  always_comb begin
    if (accept && state_q == IDLE) sat_d = 1'b0;
    else sat_d = sat_q | (v0_q & clamps(prod1)) | (v1_q & clamps(prod2))
                       | (v2_q & ~first2_q & acc_clamp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end

  assign bus.sat_flag = sat_q;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.accel       = accel_q;
  assign bus.accel_valid = accel_valid_q;
  assign bus.term_count  = term_count_q;
endmodule

// File: tb/tb_accel_accumulator.sv
// Self-checking bench for accel_accumulator: fixed vector table, corner sequences, random frames vs model.
module tb_accel_accumulator;
  localparam int W  = 64;
  localparam int F  = 32;
  localparam int CW = 16;

  typedef logic signed [63:0]  word_t;
  typedef logic signed [127:0] wide_t;

  localparam word_t ONE  = 64'sh0000_0001_0000_0000;
  localparam word_t HALF = 64'sh0000_0000_8000_0000;
  localparam word_t NEG1 = 64'shFFFF_FFFF_0000_0000;
  localparam word_t NEG2 = 64'shFFFF_FFFE_0000_0000;
  localparam word_t QTR  = 64'sh4000_0000_0000_0000;
  localparam word_t NQTR = 64'shC000_0000_0000_0000;
  localparam word_t WMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam word_t WMIN = 64'sh8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  accel_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  accel_accumulator #(.WIDTH(W), .FRACTIONAL(F), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  word_t qgm[$];
  word_t qir[$];
  word_t qdx[$];
  int    qgap[$];

  typedef struct {
    string name;
    int    n;
    word_t gm, ir, dx0, dx1, dx2, exp_acc;
    int    exp_cnt;
    bit    exp_sat;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact products in 128 bits, floor division by 2^F, clamp by value comparison.
  function automatic word_t sat_ref(input wide_t v, inout bit s);
    if (v > wide_t'(WMAX)) begin s = 1'b1; return WMAX; end
    if (v < wide_t'(WMIN)) begin s = 1'b1; return WMIN; end
    return word_t'(v);
  endfunction

  function automatic word_t fx_ref(input word_t a, input word_t b, inout bit s);
    wide_t ea;
    wide_t eb;
    ea = a;
    eb = b;
    return sat_ref((ea * eb) >>> F, s);
  endfunction

  function automatic void ref_frame(output word_t acc_o, output bit sat_o);
    wide_t acc;
    word_t t;
    bit    s;
    s   = 1'b0;
    acc = '0;
    foreach (qgm[i]) begin
      t = fx_ref(qgm[i], qir[i], s);
      t = fx_ref(t, qdx[i], s);
      if (i == 0) acc = t;
      else        acc = sat_ref(acc + wide_t'(t), s);
    end
    acc_o = word_t'(acc);
    sat_o = s;
  endfunction

  function automatic void clear_beats();
    qgm.delete(); qir.delete(); qdx.delete(); qgap.delete();
  endfunction

  function automatic void push_beat(input word_t gm, input word_t ir, input word_t dx, input int gap);
    qgm.push_back(gm); qir.push_back(ir); qdx.push_back(dx); qgap.push_back(gap);
  endfunction

  function automatic void add_vec(input string nm, input int n, input word_t gm, input word_t ir,
                                  input word_t d0, input word_t d1, input word_t d2,
                                  input word_t exp_acc, input int cnt, input bit s);
    vec_t v;
    v.name = nm; v.n = n; v.gm = gm; v.ir = ir;
    v.dx0 = d0; v.dx1 = d1; v.dx2 = d2;
    v.exp_acc = exp_acc; v.exp_cnt = cnt; v.exp_sat = s;
    vt.push_back(v);
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1, 2:    return word_t'($signed($urandom)) <<< $urandom_range(0, 8);
      default: return ONE;
    endcase
  endfunction

  task automatic junk_inputs;
    bus_if.in_valid  = 1'($urandom);
    bus_if.in_last   = 1'($urandom);
    bus_if.in_gm     = {$urandom, $urandom};
    bus_if.in_inv_r3 = {$urandom, $urandom};
    bus_if.in_dx     = {$urandom, $urandom};
  endtask

  // Sends the queued beats, then checks latency, result, hold under backpressure and release.
  task automatic run_frame(input string tag, input int bp, input word_t exp_acc,
                           input int exp_cnt, input bit exp_sat);
    int    n;
    int    lat;
    word_t got;
    n = qgm.size();
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < qgap[i]; g++) begin
        junk_inputs();
        bus_if.in_valid = 1'b0;
        tick();
      end
      bus_if.in_valid    = 1'b1;
      bus_if.in_gm       = qgm[i];
      bus_if.in_inv_r3   = qir[i];
      bus_if.in_dx       = qdx[i];
      bus_if.in_last     = (i == n - 1);
      bus_if.accel_ready = 1'($urandom);
      check({tag, "_in_ready_open"}, 64'(bus_if.in_ready), 64'd1);
      tick();
    end
    lat = 0;
    while (!bus_if.accel_valid && lat < 20) begin
      junk_inputs();
      check({tag, "_in_ready_drain"}, 64'(bus_if.in_ready), 64'd0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    got = bus_if.accel;
    check({tag, "_accel"}, got, exp_acc);
    check({tag, "_term_count"}, 64'(bus_if.term_count), 64'(exp_cnt));
`ifdef ACCEL_SAT_FLAG_EN
    check({tag, "_sat_flag"}, 64'(bus_if.sat_flag), 64'(exp_sat));
`else
    if (exp_sat) begin end
`endif
    for (int b = 0; b < bp; b++) begin
      junk_inputs();
      bus_if.accel_ready = 1'b0;
      tick();
      check({tag, "_bp_valid"}, 64'(bus_if.accel_valid), 64'd1);
      check({tag, "_bp_accel"}, bus_if.accel, got);
      check({tag, "_bp_count"}, 64'(bus_if.term_count), 64'(exp_cnt));
      check({tag, "_bp_in_ready"}, 64'(bus_if.in_ready), 64'd0);
    end
    junk_inputs();
    bus_if.accel_ready = 1'b1;
    tick();
    bus_if.accel_ready = 1'b0;
    bus_if.in_valid    = 1'b0;
    check({tag, "_hs_valid"}, 64'(bus_if.accel_valid), 64'd0);
    check({tag, "_hs_in_ready"}, 64'(bus_if.in_ready), 64'd1);
    check({tag, "_hs_accel_hold"}, bus_if.accel, got);
    check({tag, "_hs_count_hold"}, 64'(bus_if.term_count), 64'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests so far %0d", n_tests);
    $fatal(1);
  end

  initial begin
    word_t exp_acc;
    bit    exp_sat;
    int    n;

    bus_if.in_valid = 1'b0; bus_if.in_last = 1'b0; bus_if.accel_ready = 1'b0;
    bus_if.in_gm = '0; bus_if.in_inv_r3 = '0; bus_if.in_dx = '0;

    #2;
    check("reset_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("reset_accel", bus_if.accel, 64'd0);
    check("reset_valid", 64'(bus_if.accel_valid), 64'd0);
    check("reset_count", 64'(bus_if.term_count), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_in_ready", 64'(bus_if.in_ready), 64'd1);

    add_vec("single",     1, 64'sh2_0000_0000, HALF, 64'sh3_0000_0000, 0, 0, 64'sh3_0000_0000, 1, 1'b0);
    add_vec("three",      3, ONE, ONE, ONE, NEG2, HALF, 64'shFFFF_FFFF_8000_0000, 3, 1'b0);
    add_vec("sat_pos",    1, QTR, QTR, ONE, 0, 0, WMAX, 1, 1'b1);
    add_vec("sat_neg_dx", 1, QTR, QTR, NEG1, 0, 0, 64'sh8000_0000_0000_0001, 1, 1'b1);
    add_vec("sat_min",    1, QTR, NQTR, ONE, 0, 0, WMIN, 1, 1'b1);
    add_vec("clean",      1, ONE, ONE, ONE, 0, 0, ONE, 1, 1'b0);
    add_vec("acc_sat",    3, QTR, ONE, ONE, ONE, ONE, WMAX, 3, 1'b1);
    add_vec("floor",      1, 64'shFFFF_FFFF_FFFF_FFFF, HALF, ONE, 0, 0, 64'shFFFF_FFFF_FFFF_FFFF, 1, 1'b0);

    foreach (vt[k]) begin
      clear_beats();
      push_beat(vt[k].gm, vt[k].ir, vt[k].dx0, 0);
      if (vt[k].n > 1) push_beat(vt[k].gm, vt[k].ir, vt[k].dx1, 0);
      if (vt[k].n > 2) push_beat(vt[k].gm, vt[k].ir, vt[k].dx2, 0);
      run_frame(vt[k].name, 0, vt[k].exp_acc, vt[k].exp_cnt, vt[k].exp_sat);
    end

    // Backpressure for five cycles, then a one-beat frame must not see the old sum.
    clear_beats();
    push_beat(64'sh2_0000_0000, HALF, 64'sh3_0000_0000, 0);
    run_frame("bp", 5, 64'sh3_0000_0000, 1, 1'b0);
    clear_beats();
    push_beat(ONE, ONE, ONE, 0);
    run_frame("after_bp", 0, ONE, 1, 1'b0);

    // Gapped valid pattern 1,0,0,1,0,1.
    clear_beats();
    push_beat(ONE, ONE, ONE, 0);
    push_beat(ONE, ONE, ONE, 2);
    push_beat(ONE, ONE, ONE, 1);
    run_frame("gapped", 0, 64'sh3_0000_0000, 3, 1'b0);

    // Reset after two of four beats.
    bus_if.in_valid = 1'b1; bus_if.in_last = 1'b0;
    bus_if.in_gm = ONE; bus_if.in_inv_r3 = ONE; bus_if.in_dx = ONE;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("midrst_accel", bus_if.accel, 64'd0);
    check("midrst_valid", 64'(bus_if.accel_valid), 64'd0);
    check("midrst_count", 64'(bus_if.term_count), 64'd0);
    bus_if.in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) begin
      tick();
      check("midrst_no_result", 64'(bus_if.accel_valid), 64'd0);
    end
    clear_beats();
    push_beat(ONE, ONE, ONE, 0);
    run_frame("after_rst", 0, ONE, 1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      clear_beats();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        push_beat(rnd_word(), rnd_word(), rnd_word(), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
      ref_frame(exp_acc, exp_sat);
      run_frame("rnd", $urandom_range(0, 3), exp_acc, n, exp_sat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
